// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and TX FSM states shared by the UART MMIO block.
package uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_FULL     = 2;
    localparam int ST_TX_EMPTY    = 3;
    localparam int ST_TX_IDLE     = 4;
    localparam int ST_RX_OVERRUN  = 5;
    localparam int ST_RX_BREAK    = 6;
    localparam int ST_TX_OVERFLOW = 7;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: show-ahead synchronous FIFO; a pop on a full FIFO frees room for a same-cycle push.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_ok_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    assign empty_o   = count_q == '0;
    assign full_o    = count_q == (AW+1)'(DEPTH);
    assign do_pop    = pop_i & ~empty_o;
    assign push_ok_o = push_i & (~full_o | do_pop);
    assign dout_o    = mem_q[rd_q];
    assign count_o   = count_q;
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_o) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok_o) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: bit-level receiver; samples mid-bit, flags a break when data and stop bit are all zero.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB) + 1;
    logic [1:0]              sync_q;
    logic                    act_q, valid_q, brk_q, rxs;
    logic [CW-1:0]           cyc_q, lim;
    logic [3:0]              idx_q;
    logic [PAYLOAD_BITS-1:0] sh_q;
    assign rxs           = sync_q[1];
    assign lim           = idx_q == 4'd0 ? CW'(CPB / 2 - 1) : CW'(CPB - 1);
    assign uart_rx_valid = valid_q;
    assign uart_rx_break = brk_q;
    assign uart_rx_data  = sh_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= 2'b11;
            act_q   <= 1'b0;
            cyc_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rxd};
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
            if (!act_q) begin
                cyc_q <= '0;
                idx_q <= '0;
                act_q <= uart_rx_en & ~rxs;
            end else if (cyc_q != lim) begin
                cyc_q <= cyc_q + CW'(1);
            end else begin
                cyc_q <= '0;
                if (idx_q == 4'd0) begin
                    act_q <= ~rxs;
                    idx_q <= 4'd1;
                end else if (idx_q <= 4'(PAYLOAD_BITS)) begin
                    sh_q  <= {rxs, sh_q[PAYLOAD_BITS-1:1]};
                    idx_q <= idx_q + 4'd1;
                end else begin
                    act_q   <= 1'b0;
                    valid_q <= rxs;
                    brk_q   <= ~rxs & (sh_q == '0);
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: bit-level transmitter; 8N1-style frame, LSB first, busy held for the whole frame.
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB) + 1;
    localparam int FB  = PAYLOAD_BITS + 2;
    logic          busy_q;
    logic [CW-1:0] cyc_q;
    logic [3:0]    bit_q;
    logic [FB-1:0] sh_q;
    assign uart_tx_busy = busy_q;
    assign uart_txd     = busy_q ? sh_q[0] : 1'b1;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cyc_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
        end else if (!busy_q) begin
            if (uart_tx_en) begin
                busy_q <= 1'b1;
                cyc_q  <= '0;
                bit_q  <= '0;
                sh_q   <= {1'b1, uart_tx_data, 1'b0};
            end
        end else if (cyc_q == CW'(CPB - 1)) begin
            cyc_q <= '0;
            sh_q  <= {1'b1, sh_q[FB-1:1]};
            if (bit_q == 4'(FB - 1)) busy_q <= 1'b0;
            else bit_q <= bit_q + 4'd1;
        end else begin
            cyc_q <= cyc_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped UART with TX/RX FIFOs, sticky error flags, CTRL and registered irq.
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter int          CLK_HZ       = 10_000_000,
    parameter int          BIT_RATE     = 9600,
    parameter int          PAYLOAD_BITS = 8,
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 16,
    parameter logic [63:0] ADDR_BASE    = 64'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        uart_txd,
    input  logic [63:0] uart_addr,
    input  logic [31:0] uart_write_data,
    input  logic        uart_wen,
    input  logic        uart_ren,
    output logic [31:0] uart_read_data,
    output logic        irq,
    output logic [7:0]  led
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    logic                    sel, wr_data, wr_status, wr_ctrl, rd_data, core_rstn;
    logic [1:0]              ridx;
    logic [PAYLOAD_BITS-1:0] tx_head, rx_head, rx_byte;
    logic                    tx_full, tx_empty, tx_push_ok, tx_pop, tx_en, tx_busy;
    logic                    rx_full, rx_empty, rx_push_ok, rx_valid, rx_break;
    logic [TCW-1:0]          tx_count;
    logic [RCW-1:0]          rx_count;
    tx_state_e               state_q, state_d;
    logic [1:0]              tmo_q, tmo_d;
    logic                    ovr_q, ovr_d, brk_q, brk_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic [7:0]              led_q, led_d;
    logic [31:0]             status;
    logic                    unused_bits;
    assign sel         = uart_addr[63:4] == ADDR_BASE[63:4];
    assign ridx        = uart_addr[3:2];
    assign wr_data     = sel & uart_wen & (ridx == REG_DATA);
    assign wr_status   = sel & uart_wen & (ridx == REG_STATUS);
    assign wr_ctrl     = sel & uart_wen & (ridx == REG_CTRL);
    assign rd_data     = sel & uart_ren & (ridx == REG_DATA);
    assign core_rstn   = ~rst;
    assign unused_bits = ^{uart_addr[1:0], uart_write_data[31:8]};
    uart_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(wr_data), .pop_i(tx_pop),
        .din_i(uart_write_data[PAYLOAD_BITS-1:0]), .dout_o(tx_head),
        .full_o(tx_full), .empty_o(tx_empty), .push_ok_o(tx_push_ok), .count_o(tx_count)
    );
    uart_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_valid), .pop_i(rd_data),
        .din_i(rx_byte), .dout_o(rx_head),
        .full_o(rx_full), .empty_o(rx_empty), .push_ok_o(rx_push_ok), .count_o(rx_count)
    );
    uart_tx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(PAYLOAD_BITS)) u_tx (
        .clk(clk), .resetn(core_rstn), .uart_txd(uart_txd), .uart_tx_busy(tx_busy),
        .uart_tx_en(tx_en), .uart_tx_data(tx_head)
    );
    uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(PAYLOAD_BITS)) u_rx (
        .clk(clk), .resetn(core_rstn), .uart_rxd(uart_rxd), .uart_rx_en(1'b1),
        .uart_rx_break(rx_break), .uart_rx_valid(rx_valid), .uart_rx_data(rx_byte)
    );
    // WAIT_DONE jumps straight to LOAD so queued bytes leave with at most two idle cycles between frames.
    always_comb begin
        state_d = state_q;
        tmo_d   = 2'd0;
        tx_en   = 1'b0;
        tx_pop  = 1'b0;
        case (state_q)
            IDLE:      if (!tx_empty && !tx_busy) state_d = LOAD;
            LOAD: begin
                tx_en   = 1'b1;
                tx_pop  = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) state_d = WAIT_DONE;
                else if (tmo_q == 2'd3) state_d = IDLE;
                else tmo_d = tmo_q + 2'd1;
            end
            WAIT_DONE: if (!tx_busy) state_d = tx_empty ? IDLE : LOAD;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = ~rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_IDLE]     = tx_empty & (state_q == IDLE);
        status[ST_RX_OVERRUN]  = ovr_q;
        status[ST_RX_BREAK]    = brk_q;
        status[ST_TX_OVERFLOW] = ovf_q;
        status[15:8]           = 8'(rx_count);
        status[23:16]          = 8'(tx_count);
    end
    // Sticky flags: a set event in the same cycle as a write-1-to-clear keeps the flag set.
    always_comb begin
        ovr_d  = (rx_valid & ~rx_push_ok) | (ovr_q & ~(wr_status & uart_write_data[ST_RX_OVERRUN]));
        brk_d  = rx_break | (brk_q & ~(wr_status & uart_write_data[ST_RX_BREAK]));
        ovf_d  = (wr_data & ~tx_push_ok) | (ovf_q & ~(wr_status & uart_write_data[ST_TX_OVERFLOW]));
        ctrl_d = wr_ctrl ? uart_write_data[2:0] : ctrl_q;
        led_d  = rx_push_ok ? 8'(rx_byte) : tx_push_ok ? 8'(uart_write_data[PAYLOAD_BITS-1:0]) : led_q;
        irq_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | (ctrl_q[2] & |status[7:5]);
        uart_read_data = !sel ? 32'd0
                       : ridx == REG_DATA   ? (rx_empty ? 32'd0 : 32'(rx_head))
                       : ridx == REG_STATUS ? status
                       : ridx == REG_CTRL   ? {29'd0, ctrl_q}
                       : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= 2'd0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ctrl_q  <= 3'd0;
            led_q   <= 8'hF0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
            ovf_q   <= ovf_d;
            ctrl_q  <= ctrl_d;
            led_q   <= led_d;
            irq_q   <= irq_d;
        end
    end
    assign irq = irq_q;
    assign led = led_q;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed scoreboard bench; register/pin expectations and TX frames are queued and checked by monitors.
module tb_uart_mmio_fifo;
    localparam logic [63:0] BASE = 64'h1000_0000;
    localparam int CPB = 8;
    localparam int K_RD = 0, K_IRQ = 1, K_LED = 2, K_TXD = 3;
    logic        clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, uart_txd;
    logic [63:0] uart_addr = BASE;
    logic [31:0] uart_write_data = '0, uart_read_data;
    logic        uart_wen = 1'b0, uart_ren = 1'b0, irq;
    logic [7:0]  led;
    int          total = 0, bad = 0;
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  exp_tx[$];
    bit          chk = 1'b0, tx_mon_en = 1'b0;
    exp_t        me;
    logic [31:0] mgot;

    uart_mmio_fifo #(.CLK_HZ(8_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
                     .TX_DEPTH(16), .RX_DEPTH(16), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .uart_addr(uart_addr), .uart_write_data(uart_write_data), .uart_wen(uart_wen),
        .uart_ren(uart_ren), .uart_read_data(uart_read_data), .irq(irq), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic string kname(int k);
        return k == K_RD ? "read_data" : k == K_IRQ ? "irq" : k == K_LED ? "led" : "uart_txd";
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty got=none want=entry");
            end else begin
                me = exp_q.pop_front();
                mgot = me.kind == K_RD ? uart_read_data : me.kind == K_IRQ ? 32'(irq)
                     : me.kind == K_LED ? 32'(led) : 32'(uart_txd);
                if (mgot !== me.val) begin
                    bad++;
                    $display("FAIL %s check#%0d got=%h want=%h", kname(me.kind), total, mgot, me.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
        chk = 1'b1;
        step();
        chk = 1'b0;
    endtask

    task automatic rd_at(input logic [63:0] a, input bit pop, input logic [31:0] v);
        uart_addr = a;
        uart_ren  = pop;
        expect_v(K_RD, v);
        uart_ren  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, input bit pop, input logic [31:0] v);
        rd_at(BASE | 64'({r, 2'b00}), pop, v);
    endtask

    task automatic wr_at(input logic [63:0] a, input logic [31:0] d);
        uart_addr       = a;
        uart_write_data = d;
        uart_wen        = 1'b1;
        step();
        uart_wen        = 1'b0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        wr_at(BASE | 64'({r, 2'b00}), d);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        uart_rxd = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) step();
        end
        uart_rxd = 1'b1;
        repeat (CPB) step();
    endtask

    task automatic wait_rx_valid(output bit found);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            if (dut.rx_valid) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL rx_valid_timeout got=0 want=1");
        end
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 2000 && exp_tx.size() != 0; i++) step();
        total++;
        if (exp_tx.size() != 0) begin
            bad++;
            $display("FAIL tx_frames_pending got=%0d want=0", exp_tx.size());
        end
    endtask

    // Decodes frames on uart_txd at mid-bit and compares them against the expected byte queue.
    initial begin
        logic [7:0] d;
        logic       sb, st;
        forever begin
            @(negedge uart_txd);
            if (tx_mon_en && !rst) begin
                repeat (4) step();
                st = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) step();
                    d[i] = uart_txd;
                end
                repeat (CPB) step();
                sb = uart_txd;
                total++;
                if (exp_tx.size() == 0) begin
                    bad++;
                    $display("FAIL tx_frame_unexpected got=%h want=none", d);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (d !== e || sb !== 1'b1 || st !== 1'b0)
                        begin
                            bad++;
                            $display("FAIL tx_frame got=%h start=%b stop=%b want=%h start=0 stop=1", d, st, sb, e);
                        end
                end
            end
        end
    end

    initial begin
        bit found;
        step();
        rst = 1'b0;
        // reset state and register map basics
        rd(2'd1, 1'b0, 32'h0000_0018);
        expect_v(K_IRQ, 32'd0);
        expect_v(K_LED, 32'hF0);
        expect_v(K_TXD, 32'd1);
        rd(2'd2, 1'b0, 32'd0);
        rd(2'd0, 1'b1, 32'd0);
        wr(2'd3, 32'hFF);
        rd(2'd3, 1'b0, 32'd0);
        wr_at(BASE + 64'h10, 32'h77);
        rd_at(BASE + 64'h10, 1'b0, 32'd0);
        rd(2'd1, 1'b0, 32'h0000_0018);
        // TX burst
        tx_mon_en = 1'b1;
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'hA3);
        exp_tx.push_back(8'h0F);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'hA3);
        wr(2'd0, 32'h0F);
        rd(2'd1, 1'b0, 32'h0002_0000);
        expect_v(K_LED, 32'h0F);
        wait_tx();
        repeat (12) step();
        rd(2'd1, 1'b0, 32'h0000_0018);
        // TX overflow while the core is busy with a frame
        tx_mon_en = 1'b0;
        wr(2'd0, 32'h00);
        repeat (6) step();
        for (int i = 1; i <= 17; i++) wr(2'd0, 32'(i));
        rd(2'd1, 1'b0, 32'h0010_0084);
        expect_v(K_LED, 32'h10);
        wr(2'd1, 32'h80);
        rd(2'd1, 1'b0, 32'h0010_0004);
        reset_dut();
        expect_v(K_TXD, 32'd1);
        rd(2'd1, 1'b0, 32'h0000_0018);
        repeat (4) step();
        tx_mon_en = 1'b1;
        // RX buffering and overrun
        for (int b = 1; b <= 17; b++) send_rx(8'(b));
        repeat (4) step();
        rd(2'd1, 1'b0, 32'h0000_103B);
        expect_v(K_LED, 32'h10);
        for (int b = 1; b <= 16; b++) rd(2'd0, 1'b1, 32'(b));
        rd(2'd0, 1'b1, 32'd0);
        rd(2'd1, 1'b0, 32'h0000_0038);
        wr(2'd1, 32'h20);
        rd(2'd1, 1'b0, 32'h0000_0018);
        // full RX: CPU pop coincides with a received byte
        for (int b = 8'h21; b <= 8'h30; b++) send_rx(8'(b));
        fork
            send_rx(8'h31);
            begin
                wait_rx_valid(found);
                if (found) rd(2'd0, 1'b1, 32'h21);
            end
        join
        repeat (4) step();
        rd(2'd1, 1'b0, 32'h0000_101B);
        for (int b = 8'h22; b <= 8'h31; b++) rd(2'd0, 1'b1, 32'(b));
        rd(2'd1, 1'b0, 32'h0000_0018);
        // irq on RX data, one-cycle lag on set and clear
        wr(2'd2, 32'd1);
        rd(2'd2, 1'b0, 32'd1);
        expect_v(K_IRQ, 32'd0);
        fork
            send_rx(8'h5A);
            begin
                wait_rx_valid(found);
                if (found) begin
                    step();
                    expect_v(K_IRQ, 32'd0);
                    expect_v(K_IRQ, 32'd1);
                end
            end
        join
        expect_v(K_LED, 32'h5A);
        rd(2'd0, 1'b1, 32'h5A);
        expect_v(K_IRQ, 32'd1);
        expect_v(K_IRQ, 32'd0);
        wr(2'd2, 32'd2);
        step();
        expect_v(K_IRQ, 32'd1);
        // reset in the middle of a TX frame
        tx_mon_en = 1'b0;
        wr(2'd0, 32'hC3);
        wr(2'd0, 32'h3C);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            step();
            if (uart_txd === 1'b0) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL tx_start_timeout got=1 want=0");
        end
        step();
        expect_v(K_TXD, 32'd0);
        reset_dut();
        expect_v(K_TXD, 32'd1);
        rd(2'd1, 1'b0, 32'h0000_0018);
        expect_v(K_IRQ, 32'd0);
        expect_v(K_LED, 32'hF0);
        rd(2'd2, 1'b0, 32'd0);
        repeat (100) step();
        expect_v(K_TXD, 32'd1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
